// File: rtl/tts_pkg.sv
// tts_pkg: shared state encoding and default sizing for the truth-table sweeper
package tts_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int N_IN_DEF = 4;
    localparam int DEPTH    = 2 ** N_IN_DEF;
    localparam int CNT_W    = N_IN_DEF + 1;
endpackage

// File: rtl/tts_hold_timer.sv
// tts_hold_timer: per-vector hold down-counter with last-cycle strobe
//   clk, rst_n  clock, async active-low reset
//   clr         reload to HOLD_CYCLES-1 (vector advance, abort, not running)
//   en          count down while the sweep runs
//   last        high on the final hold cycle of the current vector
module tts_hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int W = $clog2(HOLD_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= W'(HOLD_CYCLES - 1);
        else if (clr) cnt <= W'(HOLD_CYCLES - 1);
        else if (en) cnt <= cnt - W'(1);
    assign last = en && cnt == '0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive sweep of an N_IN-input function with truth-table capture and compare
//   clk, rst_n    clock, async active-low reset
//   start, abort  begin sweep (IDLE only) / cancel sweep without done
//   expected      golden table, latched on accepted start
//   f_in          DUT response to w_out
//   w_out         current input vector
//   busy, done    running / one-cycle completion pulse
//   truth_table   captured responses, bit i = f(i)
//   mismatch_cnt  differing bits versus expected
//   pass          no mismatches, valid from done until next start
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN        = N_IN_DEF,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2**N_IN-1:0]    expected,
    input  logic                  f_in,
    output logic [N_IN-1:0]       w_out,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    truth_table,
    output logic [N_IN:0]         mismatch_cnt,
    output logic                  pass
);
    localparam int D  = 2 ** N_IN;
    localparam int CW = N_IN + 1;
    state_t       state;
    logic [D-1:0] exp_q;
    logic         last, miss, clr;
    assign miss = f_in != exp_q[w_out];
    assign clr  = state != RUN || last || abort;
    tts_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .en   (state == RUN),
        .last (last)
    );
    // pass is decided on the final sample edge so it already includes the last compare
    // and is valid in the same cycle as done
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            w_out        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            truth_table  <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            exp_q        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    state        <= RUN;
                    busy         <= 1'b1;
                    w_out        <= '0;
                    truth_table  <= '0;
                    mismatch_cnt <= '0;
                    pass         <= 1'b0;
                    exp_q        <= expected;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    w_out <= '0;
                end else if (last) begin
                    truth_table[w_out] <= f_in;
                    mismatch_cnt       <= mismatch_cnt + CW'(miss);
                    if (w_out == '1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= mismatch_cnt == '0 && !miss;
                    end else begin
                        w_out <= w_out + N_IN'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    w_out <= '0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: randomized self-checking bench against a table-level reference model
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] expected = '0, lut = '0;
    logic        f_in;
    logic [3:0]  w_out;
    logic        busy, done, pass;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_cnt;
    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [3:0]  expected2 = '0;
    logic        f2;
    logic [1:0]  w2;
    logic        busy2, done2, pass2;
    logic [3:0]  tt2;
    logic [2:0]  mc2;
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;
    assign f_in = lut[w_out];
    assign f2   = &w2;

    truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .f_in(f_in), .w_out(w_out), .busy(busy), .done(done), .truth_table(truth_table),
        .mismatch_cnt(mismatch_cnt), .pass(pass)
    );
    truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(expected2),
        .f_in(f2), .w_out(w2), .busy(busy2), .done(done2), .truth_table(tt2),
        .mismatch_cnt(mc2), .pass(pass2)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({busy, done, pass, w_out, truth_table, mismatch_cnt} !== 27'd0) begin
            errors++;
            $display("FAIL reset_idle got %h want 0", {busy, done, pass, w_out, truth_table, mismatch_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        lut = 16'($urandom);
        expected = 16'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, pass, w_out, truth_table, mismatch_cnt} !== 27'd0) begin
            errors++;
            $display("FAIL reset_run got %h want 0", {busy, done, pass, w_out, truth_table, mismatch_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, w_out} !== 6'd0) begin
            errors++;
            $display("FAIL reset_release_idle got %h want 0", {busy, done, w_out});
        end
    endtask

    // One sweep of the 4-input instance. restart_cyc re-asserts start and flips expected
    // mid-run; abort_cyc pulses abort for one cycle (0 = unused).
    task automatic sweep(input logic [15:0] f, input logic [15:0] e, input int restart_cyc, input int abort_cyc);
        int pulses, done_cyc;
        logic [15:0] tt;
        logic [4:0] mc;
        logic ps;
        bit aborted;
        pulses = 0;
        done_cyc = -1;
        tt = '0;
        mc = '0;
        ps = 1'b0;
        aborted = abort_cyc > 0 && abort_cyc <= 32;
        lut = f;
        expected = e;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 32 && (!aborted || c <= abort_cyc)) begin
                vectors++;
                if ({busy, w_out} !== {1'b1, 4'((c - 1) / 2)}) begin
                    errors++;
                    $display("FAIL run_vector cyc %0d got busy=%b w=%0d want busy=1 w=%0d", c, busy, w_out, (c - 1) / 2);
                end
            end
            if (done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    tt = truth_table;
                    mc = mismatch_cnt;
                    ps = pass;
                end
            end
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                abort = 1'b0;
                vectors++;
                if ({busy, w_out} !== 5'd0) begin
                    errors++;
                    $display("FAIL abort_exit got busy=%b w=%0d want busy=0 w=0", busy, w_out);
                end
            end
            if (c == abort_cyc) abort = 1'b1;
            if (c == restart_cyc + 1) start = 1'b0;
            if (c == restart_cyc) begin
                start = 1'b1;
                expected = ~e;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        if (aborted) begin
            vectors++;
            if ({pulses, pass, busy} !== {32'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL abort_result got pulses=%0d pass=%b busy=%b want 0 0 0", pulses, pass, busy);
            end
        end else begin
            vectors++;
            if (pulses !== 1 || done_cyc !== 33) begin
                errors++;
                $display("FAIL done_timing got pulses=%0d cyc=%0d want 1 at 33", pulses, done_cyc);
            end
            vectors++;
            if (tt !== f) begin
                errors++;
                $display("FAIL truth_table got %h want %h", tt, f);
            end
            vectors++;
            if (mc !== 5'($countones(f ^ e)) || ps !== (f == e)) begin
                errors++;
                $display("FAIL compare got cnt=%0d pass=%b want cnt=%0d pass=%b", mc, ps, $countones(f ^ e), f == e);
            end
            vectors++;
            if (pass !== (f == e)) begin
                errors++;
                $display("FAIL pass_hold got %b want %b", pass, f == e);
            end
        end
    endtask

    task automatic test_walking_one;
        sweep(16'hAAAA, 16'hAAAA, 0, 0);
    endtask

    task automatic test_parity;
        sweep(16'h6996, 16'hAAAA, 0, 0);
    endtask

    task automatic test_abort;
        sweep(16'h6996, 16'hAAAA, 0, 10);
        sweep(16'h6996, 16'h6996, 0, 0);
        sweep(16'($urandom), 16'($urandom), 0, 33);
    endtask

    task automatic test_restart_ignored;
        sweep(16'hAAAA, 16'hAAAA, 5, 0);
    endtask

    task automatic test_random;
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            sweep(r, (i == 0) ? r : 16'($urandom), 0, 0);
        end
    endtask

    task automatic test_start_abort;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL start_abort got busy=%b done=%b want 0 0", busy, done);
            end
        end
    endtask

    task automatic test_small;
        logic [3:0] e;
        int done_cyc;
        for (int i = 0; i < 3; i++) begin
            e = (i == 0) ? 4'b1000 : 4'($urandom);
            expected2 = e;
            done_cyc = -1;
            @(negedge clk);
            start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (done2 && done_cyc < 0) begin
                    done_cyc = c;
                    vectors++;
                    if ({tt2, mc2, pass2} !== {4'b1000, 3'($countones(e ^ 4'b1000)), e == 4'b1000}) begin
                        errors++;
                        $display("FAIL small_result got tt=%b cnt=%0d pass=%b exp=%b", tt2, mc2, pass2, e);
                    end
                end
            end
            vectors++;
            if (done_cyc !== 5) begin
                errors++;
                $display("FAIL small_done_cyc got %0d want 5", done_cyc);
            end
        end
    endtask

    initial begin
        test_reset;
        test_walking_one;
        test_parity;
        test_abort;
        test_restart_ignored;
        test_random;
        test_start_abort;
        test_small;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
